// File: rtl/foo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : foo_pkg
//  Description : Shared types, defaults and helpers for the foo edge collector.
//  Revision    : 1.0 - initial release
// ============================================================================
package foo_pkg;

  localparam int N_DEF     = 4;
  localparam int CNT_W_DEF = 8;

  // Lane index width: never narrower than one bit, even for a single lane.
  function automatic int lane_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int LANE_W_DEF = lane_w(N_DEF);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_e;

  typedef struct packed {
    logic [LANE_W_DEF-1:0] lane;
    logic [CNT_W_DEF-1:0]  count;
  } evt_t;

endpackage
`default_nettype wire

// File: rtl/foo_intf.sv
`default_nettype none
// ============================================================================
//  Module      : foo_intf
//  Description : Single-bit lane interface; the collector consumes it as sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface foo_intf;
  logic a;
  modport sink   (input  a);
  modport source (output a);
endinterface
`default_nettype wire

// File: rtl/foo_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : foo_rr_pick
//  Description : Combinational round-robin picker: first set request bit
//                strictly after ptr_i, wrapping around to lane 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module foo_rr_pick #(
  parameter int N      = 4,
  parameter int LANE_W = 2
) (
  input  logic [N-1:0]      req_i,
  input  logic [LANE_W-1:0] ptr_i,
  output logic              any_o,
  output logic [LANE_W-1:0] grant_idx_o
);

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    int idx;
    any_o       = 1'b0;
    grant_idx_o = '0;
    idx         = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_i[idx]) begin
        any_o       = 1'b1;
        grant_idx_o = LANE_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/foo_edge_collector.sv
`default_nettype none
// ============================================================================
//  Module      : foo_edge_collector
//  Description : Detects rising edges on an array of foo_intf lanes, coalesces
//                them into saturating per-lane counters and drains them as
//                {lane, count} events over valid/ready, round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module foo_edge_collector
  import foo_pkg::*;
#(
  parameter  int N      = N_DEF,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int LANE_W = lane_w(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  foo_intf.sink             foos [N-1:0],
  input  logic              clear,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [LANE_W-1:0] evt_lane,
  output logic [CNT_W-1:0]  evt_count,
  output logic [N-1:0]      overflow
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(N - 1);

  logic [N-1:0]            a_in;
  logic [N-1:0]            a_q;
  logic [N-1:0]            a_dly_q;
  logic                    primed_q;
  logic [N-1:0]            rise;

  logic [N-1:0][CNT_W-1:0] cnt_q;
  logic [N-1:0][CNT_W-1:0] cnt_d;
  logic [N-1:0]            ovf_q;
  logic [N-1:0]            ovf_d;
  logic [N-1:0]            req;

  state_e                  state_q;
  state_e                  state_d;
  logic                    load;
  logic                    any;
  logic [LANE_W-1:0]       grant_idx;
  logic [LANE_W-1:0]       ptr_q;
  logic [LANE_W-1:0]       evt_lane_q;
  logic [CNT_W-1:0]        evt_count_q;

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign a_in[g] = foos[g].a;
  end

  // Input sampling; on the priming clock both stages load the live level so
  // a lane already high at reset release never looks like a fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      a_dly_q  <= '0;
      primed_q <= 1'b0;
    end else begin
      a_q      <= a_in;
      a_dly_q  <= primed_q ? a_q : a_in;
      primed_q <= 1'b1;
    end
  end

  assign rise = {N{primed_q}} & a_q & ~a_dly_q;

  // Pending counter update: clear, then grant (restart keeps a coincident
  // rise), then saturating increment with sticky overflow.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < N; i++) begin
      if (clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (load && (grant_idx == LANE_W'(i))) begin
        cnt_d[i] = rise[i] ? CNT_W'(1) : '0;
      end else if (rise[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A lane requests service whenever it holds at least one pending edge.
  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = (cnt_q[i] != '0);
    end
  end

  foo_rr_pick #(
    .N      (N),
    .LANE_W (LANE_W)
  ) u_pick (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .any_o       (any),
    .grant_idx_o (grant_idx)
  );

  // Output FSM next state; a load happens on entry to VALID or on a
  // handshake that finds more work, giving one event per cycle.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          load    = 1'b1;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (evt_ready) begin
          load    = any;
          state_d = any ? ST_VALID : ST_IDLE;
        end
      end
    endcase
  end

  // State, counters, round-robin pointer and the presented event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ovf_q       <= '0;
      ptr_q       <= LANE_LAST;
      evt_lane_q  <= '0;
      evt_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (load) begin
        ptr_q       <= grant_idx;
        evt_lane_q  <= grant_idx;
        evt_count_q <= cnt_q[grant_idx];
      end
    end
  end

  assign evt_valid = (state_q == ST_VALID);
  assign evt_lane  = evt_lane_q;
  assign evt_count = evt_count_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_foo_edge_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_foo_edge_collector
//  Description : Directed self-checking bench for foo_edge_collector
//                (default widths plus a 3-bit counter instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_foo_edge_collector;

  localparam int N = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] a_drv;
  logic       clear;
  logic       ready;
  logic       ready3;

  logic       v;
  logic [1:0] lane;
  logic [7:0] cnt;
  logic [3:0] ovf;

  logic       v3;
  logic [1:0] lane3;
  logic [2:0] cnt3;
  logic [3:0] ovf3;

  int n_checks = 0;
  int n_pass   = 0;
  int nev;
  int exp_lane;

  foo_intf u_if  [N-1:0] ();
  foo_intf u_if3 [N-1:0] ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign u_if[g].a  = a_drv[g];
    assign u_if3[g].a = a_drv[g];
  end

  foo_edge_collector #(.N(N), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .foos      (u_if),
    .clear     (clear),
    .evt_valid (v),
    .evt_ready (ready),
    .evt_lane  (lane),
    .evt_count (cnt),
    .overflow  (ovf)
  );

  foo_edge_collector #(.N(N), .CNT_W(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .foos      (u_if3),
    .clear     (clear),
    .evt_valid (v3),
    .evt_ready (ready3),
    .evt_lane  (lane3),
    .evt_count (cnt3),
    .overflow  (ovf3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_drv = '0;
    clear = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    rst_n  = 1'b0;
    a_drv  = '0;
    clear  = 1'b0;
    ready  = 1'b1;
    ready3 = 1'b1;
    step();
    chk("rst_valid", 32'(v), 0);
    chk("rst_lane", 32'(lane), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    step();
    step();

    // Single rise on lane 2: valid exactly 2 cycles after the sampling edge.
    a_drv[2] = 1'b1;
    step();
    chk("t1_lat_k", 32'(v), 0);
    step();
    chk("t1_lat_k1", 32'(v), 0);
    step();
    chk("t1_valid", 32'(v), 1);
    chk("t1_lane", 32'(lane), 2);
    chk("t1_count", 32'(cnt), 1);
    step();
    chk("t1_one_cycle", 32'(v), 0);

    // Lanes 0,1,3 rising together drain back-to-back in order.
    do_reset();
    a_drv = 4'b1011;
    step();
    step();
    step();
    chk("t2_v0", 32'(v), 1);
    chk("t2_lane0", 32'(lane), 0);
    chk("t2_cnt0", 32'(cnt), 1);
    step();
    chk("t2_v1", 32'(v), 1);
    chk("t2_lane1", 32'(lane), 1);
    chk("t2_cnt1", 32'(cnt), 1);
    step();
    chk("t2_v3", 32'(v), 1);
    chk("t2_lane3", 32'(lane), 3);
    chk("t2_cnt3", 32'(cnt), 1);
    step();
    chk("t2_done", 32'(v), 0);

    // Backpressure: lane 1 rises 5 times; first event held, rest coalesce.
    do_reset();
    ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      a_drv[1] = 1'b1;
      step();
      a_drv[1] = 1'b0;
      step();
      if (j >= 2) begin
        chk("t3_hold_v", 32'(v), 1);
        chk("t3_hold_lane", 32'(lane), 1);
        chk("t3_hold_cnt", 32'(cnt), 1);
      end
    end
    ready = 1'b1;
    step();
    chk("t3_next_v", 32'(v), 1);
    chk("t3_next_lane", 32'(lane), 1);
    chk("t3_next_cnt", 32'(cnt), 4);
    step();
    chk("t3_done", 32'(v), 0);

    // Saturation on the 3-bit instance, then clear.
    do_reset();
    ready3 = 1'b0;
    for (int j = 0; j < 11; j++) begin
      a_drv[0] = 1'b1;
      step();
      a_drv[0] = 1'b0;
      step();
    end
    chk("t4_ovf", 32'(ovf3), 1);
    chk("t4_hold_v", 32'(v3), 1);
    chk("t4_hold_lane", 32'(lane3), 0);
    chk("t4_hold_cnt", 32'(cnt3), 1);
    step();
    chk("t4_ovf_sticky", 32'(ovf3), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t4_clr_ovf", 32'(ovf3), 0);
    chk("t4_clr_v", 32'(v3), 1);
    chk("t4_clr_lane", 32'(lane3), 0);
    chk("t4_clr_cnt", 32'(cnt3), 1);
    ready3 = 1'b1;
    step();
    chk("t4_cnt_zero", 32'(v3), 0);

    // Lanes 0 and 3 toggling together: grants strictly alternate.
    do_reset();
    ready    = 1'b1;
    nev      = 0;
    exp_lane = 0;
    for (int s = 0; s < 24; s++) begin
      a_drv[0] = ~a_drv[0];
      a_drv[3] = ~a_drv[3];
      step();
      if (v) begin
        chk("t5_lane", 32'(lane), 32'(exp_lane));
        chk("t5_cnt", 32'(cnt), 1);
        exp_lane = (exp_lane == 0) ? 3 : 0;
        nev++;
      end
    end
    chk("t5_nev", 32'(nev), 22);

    // Asynchronous reset mid-event; a high lane at release makes no event.
    do_reset();
    ready    = 1'b0;
    a_drv[2] = 1'b1;
    step();
    step();
    step();
    chk("t6_pre_v", 32'(v), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_v", 32'(v), 0);
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    for (int s = 0; s < 6; s++) begin
      step();
      chk("t6_no_evt", 32'(v), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
